data_mem_periph: RTL and testbench

MEM-stage data memory for the pipelined CPU. It contains a word-addressed RAM and a memory-mapped peripheral block: timer, LEDs, 7-segment digit register and a free-running systick counter. It sits between the EX/MEM register and the MEM/WB register. Read_data feeds MEM_DM_data in the same cycle, and irq goes to the interrupt/PC control logic.

---
 rtl/data_mem_periph.sv | 114 +++++++++++
 tb/tb_data_mem_periph.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_periph.sv
// MEM-stage data memory: word RAM plus memory-mapped timer, LED, 7-segment and systick registers.
module data_mem_periph #(
  parameter int unsigned RAM_ADDR_W  = 8,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_W;
  localparam int unsigned WIDX_W    = 30;

  // Peripheral word offsets within the window
  localparam logic [WIDX_W-1:0] OFF_TH      = WIDX_W'(0);
  localparam logic [WIDX_W-1:0] OFF_TL      = WIDX_W'(1);
  localparam logic [WIDX_W-1:0] OFF_TCON    = WIDX_W'(2);
  localparam logic [WIDX_W-1:0] OFF_LED     = WIDX_W'(3);
  localparam logic [WIDX_W-1:0] OFF_DIGI    = WIDX_W'(4);
  localparam logic [WIDX_W-1:0] OFF_SYSTICK = WIDX_W'(5);
  localparam logic [WIDX_W-1:0] OFF_COUNT   = WIDX_W'(6);

  logic [31:0] ram [RAM_DEPTH];
  logic [31:0] th, tl, systick;
  logic [2:0]  tcon;

  logic [WIDX_W-1:0]     widx, poff;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  ram_hit, periph_hit;
  logic                  wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
  logic                  overflow, ovf_set;
  logic                  unused_addr;

  assign widx        = Address[31:2];
  assign ram_idx     = Address[RAM_ADDR_W+1:2];
  assign ram_hit     = (Address[31:RAM_ADDR_W+2] == '0);
  assign poff        = widx - PERIPH_BASE[31:2];
  assign periph_hit  = (poff < OFF_COUNT);
  assign unused_addr = ^Address[1:0];

  assign wr_th   = MemWr && periph_hit && (poff == OFF_TH);
  assign wr_tl   = MemWr && periph_hit && (poff == OFF_TL);
  assign wr_tcon = MemWr && periph_hit && (poff == OFF_TCON);
  assign wr_led  = MemWr && periph_hit && (poff == OFF_LED);
  assign wr_digi = MemWr && periph_hit && (poff == OFF_DIGI);

  // Timer rolls over this cycle; status is only raised when interrupts are enabled
  assign overflow = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign ovf_set  = overflow && tcon[1];
  assign irq      = tcon[2];

  // Combinational load path; unmapped or idle reads return zero
  always_comb begin
    Read_data = '0;
    if (MemRd) begin
      if (ram_hit) begin
        Read_data = ram[ram_idx];
      end else if (periph_hit) begin
        unique case (poff)
          OFF_TH:      Read_data = th;
          OFF_TL:      Read_data = tl;
          OFF_TCON:    Read_data = {29'b0, tcon};
          OFF_LED:     Read_data = {24'b0, led};
          OFF_DIGI:    Read_data = {20'b0, digi};
          OFF_SYSTICK: Read_data = systick;
          default:     Read_data = '0;
        endcase
      end
    end
  end

  // RAM store; contents survive reset but a store coinciding with reset is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (MemWr && ram_hit) begin
      ram[ram_idx] <= Write_data;
    end
  end

  // Peripheral registers: timer with CPU-write priority, LED, 7-segment, systick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr_th) th <= Write_data;
      if (wr_tl) begin
        tl <= Write_data;
      end else if (tcon[0]) begin
        tl <= overflow ? th : tl + 32'd1;
      end
      if (wr_tcon) begin
        tcon <= {Write_data[2] | ovf_set, Write_data[1:0]};
      end else if (ovf_set) begin
        tcon[2] <= 1'b1;
      end
      if (wr_led)  led  <= Write_data[7:0];
      if (wr_digi) digi <= Write_data[11:0];
    end
  end

endmodule

// File: tb/tb_data_mem_periph.sv
// Directed self-checking bench for data_mem_periph.
module tb_data_mem_periph;

  localparam logic [31:0] PB      = 32'h4000_0000;
  localparam logic [31:0] A_TH    = PB + 32'h00;
  localparam logic [31:0] A_TL    = PB + 32'h04;
  localparam logic [31:0] A_TCON  = PB + 32'h08;
  localparam logic [31:0] A_LED   = PB + 32'h0C;
  localparam logic [31:0] A_DIGI  = PB + 32'h10;
  localparam logic [31:0] A_SYST  = PB + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic [31:0] Read_data;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  int checks = 0;
  int passed = 0;
  logic [31:0] v, s0;

  data_mem_periph dut (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr),
    .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
    .led(led), .digi(digi), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs are driven 1 time unit after a posedge; a store commits on the next posedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWr = 1'b1; Address = a; Write_data = d;
    @(posedge clk); #1;
    MemWr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    MemRd = 1'b1; Address = a;
    #1 d = Read_data;
    MemRd = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(A_TH, v);   check("th_rst", v, 0);
    rd(A_TL, v);   check("tl_rst", v, 0);
    rd(A_TCON, v); check("tcon_rst", v, 0);
    rd(A_LED, v);  check("led_rd_rst", v, 0);
    rd(A_DIGI, v); check("digi_rd_rst", v, 0);
    rd(A_SYST, v); check("systick_0", v, 0);
    check("irq_rst", 32'(irq), 0);
    check("led_rst", 32'(led), 0);
    check("digi_rst", 32'(digi), 0);
    tick();
    rd(A_SYST, v); check("systick_1", v, 1);

    // RAM and decode
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, v); check("ram_rd", v, 32'hDEAD_BEEF);
    rd(32'h0000_0013, v); check("ram_rd_byteoff", v, 32'hDEAD_BEEF);
    MemWr = 1'b0; Address = 32'h0000_0010; #1 check("rd_idle_zero", Read_data, 0);
    rd(32'h0000_0400, v); check("unmapped_rd", v, 0);
    rd(PB + 32'h18, v);   check("unmapped_periph_rd", v, 0);
    wr(32'h0000_0000, 32'h1234_5678);
    wr(32'h0000_0400, 32'hFFFF_FFFF);
    rd(32'h0000_0000, v); check("unmapped_wr_no_alias", v, 32'h1234_5678);
    wr(32'h0000_03FC, 32'hA5A5_0001);
    rd(32'h0000_03FC, v); check("ram_top_word", v, 32'hA5A5_0001);

    // Timer overflow with irq
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    rd(A_TL, v); check("tl_loaded", v, 32'hFFFF_FFFE);
    tick();
    rd(A_TL, v); check("tl_ff", v, 32'hFFFF_FFFF);
    check("irq_pre_ovf", 32'(irq), 0);
    tick();
    rd(A_TL, v); check("tl_reload", v, 32'hFFFF_FFFC);
    check("irq_ovf", 32'(irq), 1);
    rd(A_TCON, v); check("tcon_status", v, 32'h7);
    tick();
    check("irq_sticky", 32'(irq), 1);
    rd(A_TL, v); check("tl_after_reload", v, 32'hFFFF_FFFD);
    wr(A_TCON, 32'h3);
    check("irq_cleared", 32'(irq), 0);
    tick();
    rd(A_TL, v); check("tl_ff2", v, 32'hFFFF_FFFF);
    // TCON write landing on the overflow edge must not lose status
    wr(A_TCON, 32'h3);
    check("irq_ovf_on_wr", 32'(irq), 1);
    rd(A_TL, v); check("tl_reload2", v, 32'hFFFF_FFFC);
    // CPU write to TL beats the increment
    wr(A_TL, 32'd5);
    rd(A_TL, v); check("tl_cpu_wins", v, 5);
    wr(A_TCON, 32'h0);
    check("irq_clr_dis", 32'(irq), 0);
    rd(A_TL, v); check("tl_last_inc", v, 6);
    tick();
    rd(A_TL, v); check("tl_hold", v, 6);

    // TH write on reload cycle: TL takes old TH; irq disabled so no status
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TH, 32'h7);
    wr(A_TCON, 32'h1);
    tick();
    rd(A_TL, v); check("tl_ff3", v, 32'hFFFF_FFFF);
    wr(A_TH, 32'h99);
    rd(A_TL, v); check("tl_old_th", v, 32'h7);
    rd(A_TH, v); check("th_new", v, 32'h99);
    check("irq_ie_off", 32'(irq), 0);
    wr(A_TCON, 32'h0);

    // LED / DIGI truncation and systick write ignored
    wr(A_LED, 32'h1A5);
    check("led_out", 32'(led), 32'hA5);
    rd(A_LED, v); check("led_rd", v, 32'hA5);
    wr(A_DIGI, 32'hF3F);
    check("digi_out", 32'(digi), 32'hF3F);
    rd(A_SYST, s0);
    wr(A_SYST, 32'h0);
    rd(A_SYST, v); check("systick_wr_ignored", v, s0 + 32'd1);

    // Reset during an in-flight store
    wr(32'h0000_0020, 32'hCAFE_F00D);
    wr(32'h0000_0024, 32'h1111_1111);
    wr(A_TCON, 32'h3);
    MemWr = 1'b1; Address = 32'h0000_0024; Write_data = 32'h2222_2222;
    #2 reset = 1'b1;
    #1 check("led_async_rst", 32'(led), 0);
    check("digi_async_rst", 32'(digi), 0);
    check("irq_async_rst", 32'(irq), 0);
    @(posedge clk); #1;
    MemWr = 1'b0;
    reset = 1'b0;
    rd(A_TL, v);   check("tl_after_rst", v, 0);
    rd(A_TCON, v); check("tcon_after_rst", v, 0);
    rd(32'h0000_0024, v); check("store_dropped", v, 32'h1111_1111);
    rd(32'h0000_0020, v); check("ram_retained", v, 32'hCAFE_F00D);
    rd(32'h0000_0010, v); check("ram_retained2", v, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
